// File: rtl/sseg_scan_capture.sv
// sseg_scan_capture: samples an active-low multiplexed 7-segment scan (an/sseg),
// decodes each digit into a shadow slot and publishes all four digits together
// once every slot has been seen. Also flags blank/invalid digits and a stale scan.
module sseg_scan_capture #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] an,
    input  logic [6:0] sseg,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic [3:0] blank,
    output logic [3:0] err,
    output logic       frame_valid,
    output logic       stale
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE_CYCLES);
    localparam logic [SW-1:0] S_ONE    = SW'(1);
    localparam logic [TW-1:0] TO_V     = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_ONE    = TW'(1);

    // decoded digit: blank flag, invalid flag, hex value
    typedef struct packed {
        logic       blank;
        logic       err;
        logic [3:0] val;
    } dig_t;

    function automatic dig_t decode(input logic [6:0] s);
        dig_t r;
        r = '{blank: 1'b0, err: 1'b0, val: 4'h0};
        case (s)
            7'h40: r.val = 4'h0;
            7'h79: r.val = 4'h1;
            7'h24: r.val = 4'h2;
            7'h30: r.val = 4'h3;
            7'h19: r.val = 4'h4;
            7'h12: r.val = 4'h5;
            7'h02: r.val = 4'h6;
            7'h78: r.val = 4'h7;
            7'h00: r.val = 4'h8;
            7'h10: r.val = 4'h9;
            7'h08: r.val = 4'hA;
            7'h03: r.val = 4'hB;
            7'h46: r.val = 4'hC;
            7'h21: r.val = 4'hD;
            7'h06: r.val = 4'hE;
            7'h0E: r.val = 4'hF;
            7'h7F: r.blank = 1'b1;
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    logic [3:0]      an_s1, an_s2, an_p;
    logic [6:0]      sseg_s1, sseg_s2, sseg_p;
    logic [SW-1:0]   stab_cnt;
    logic [TW-1:0]   tcnt;
    logic [3:0]      seen;
    logic [3:0][3:0] sh_val;
    logic [3:0]      sh_blank, sh_err;

    logic            same, legal, cap, frame_go;
    logic [1:0]      idx;
    logic [3:0]      cap_oh;
    dig_t            dec;

    // two-flop synchronizer plus one register of history for the stability compare
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_s1   <= 4'hF;
            an_s2   <= 4'hF;
            an_p    <= 4'hF;
            sseg_s1 <= 7'h7F;
            sseg_s2 <= 7'h7F;
            sseg_p  <= 7'h7F;
        end else begin
            an_s1   <= an;
            an_s2   <= an_s1;
            an_p    <= an_s2;
            sseg_s1 <= sseg;
            sseg_s2 <= sseg_s1;
            sseg_p  <= sseg_s2;
        end
    end

    // select legality, slot index, and the one-shot capture condition
    always_comb begin
        legal = 1'b1;
        idx   = 2'd0;
        case (an_s2)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: legal = 1'b0;
        endcase
        same     = ({an_s2, sseg_s2} == {an_p, sseg_p});
        // capture fires only on the transition into saturation, so a long dwell captures once
        cap      = legal && same && (stab_cnt != SETTLE_V) && ((stab_cnt + S_ONE) == SETTLE_V);
        cap_oh   = cap ? (4'b0001 << idx) : 4'b0000;
        frame_go = (seen == 4'hF);
        dec      = decode(sseg_s2);
    end

    // stability counter: counts identical legal samples, saturates, clears on change
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stab_cnt <= '0;
        else if (!legal || !same)
            stab_cnt <= '0;
        else if (stab_cnt != SETTLE_V)
            stab_cnt <= stab_cnt + S_ONE;
    end

    // shadow slots written on capture; the frame copy reads the pre-edge values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_val   <= '0;
            sh_blank <= 4'hF;
            sh_err   <= 4'h0;
        end else if (cap) begin
            sh_val[idx]   <= dec.val;
            sh_blank[idx] <= dec.blank;
            sh_err[idx]   <= dec.err;
        end
    end

    // seen mask: a capture coinciding with the frame copy starts the next frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            seen <= 4'h0;
        else if (frame_go)
            seen <= cap_oh;
        else
            seen <= seen | cap_oh;
    end

    // publish all slots together with a one-cycle strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d0          <= 4'h0;
            d1          <= 4'h0;
            d2          <= 4'h0;
            d3          <= 4'h0;
            blank       <= 4'hF;
            err         <= 4'h0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= frame_go;
            if (frame_go) begin
                d0    <= sh_val[0];
                d1    <= sh_val[1];
                d2    <= sh_val[2];
                d3    <= sh_val[3];
                blank <= sh_blank;
                err   <= sh_err;
            end
        end
    end

    // stale alarm: cycles since the last frame strobe, saturating at the timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt  <= '0;
            stale <= 1'b0;
        end else if (frame_go) begin
            tcnt  <= '0;
            stale <= 1'b0;
        end else if (tcnt != TO_V) begin
            tcnt <= tcnt + T_ONE;
            if ((tcnt + T_ONE) == TO_V)
                stale <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Scoreboard bench for sseg_scan_capture: expected frames are queued as scans are
// driven and compared when frame_valid pulses.
module tb_sseg_scan_capture;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 300;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] an = 4'hF;
    logic [6:0] sseg = 7'h7F;
    logic [3:0] d0, d1, d2, d3, blank, err;
    logic       frame_valid, stale;

    typedef struct packed {
        logic [3:0] d0, d1, d2, d3, blank, err;
    } frm_t;

    frm_t sb[$];
    int   nerr = 0;
    int   nchk = 0;
    int   frames = 0;

    sseg_scan_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .an(an), .sseg(sseg),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .blank(blank), .err(err),
        .frame_valid(frame_valid), .stale(stale)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: pop and compare on each frame strobe
    always @(negedge clk) begin
        if (!reset && frame_valid) begin
            frames++;
            chk("stale_on_frame", {31'b0, stale}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_frame", 32'd1, 32'd0);
            end else begin
                frm_t e;
                e = sb.pop_front();
                chk("d0", {28'b0, d0}, {28'b0, e.d0});
                chk("d1", {28'b0, d1}, {28'b0, e.d1});
                chk("d2", {28'b0, d2}, {28'b0, e.d2});
                chk("d3", {28'b0, d3}, {28'b0, e.d3});
                chk("blank", {28'b0, blank}, {28'b0, e.blank});
                chk("err", {28'b0, err}, {28'b0, e.err});
            end
        end
    end

    // drive digits first..last of pats ({s3,s2,s1,s0}) with the given dwell each
    task automatic scan(input logic [27:0] pats, input int dwell, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            @(posedge clk);
            #1;
            an   = ~(4'b0001 << i);
            sseg = pats[i*7 +: 7];
            repeat (dwell - 1) @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        an   = 4'hF;
        sseg = 7'h7F;
        repeat (n) @(posedge clk);
    endtask

    task automatic wait_frame(input string tag);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 60) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            chk(tag, sb.size(), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge clk);
        chk({tag, "_d"}, {16'b0, d3, d2, d1, d0}, 32'h0);
        chk({tag, "_blank"}, {28'b0, blank}, 32'hF);
        chk({tag, "_err"}, {28'b0, err}, 32'h0);
        chk({tag, "_fv"}, {31'b0, frame_valid}, 32'h0);
        chk({tag, "_stale"}, {31'b0, stale}, 32'h0);
    endtask

    initial begin
        int f0;
        repeat (3) @(posedge clk);
        check_reset_vals("rst");
        #1 reset = 1'b0;
        idle(5);

        // scan 30,24,79,40 on an0..an3
        sb.push_back('{d0: 4'h3, d1: 4'h2, d2: 4'h1, d3: 4'h0, blank: 4'h0, err: 4'h0});
        scan({7'h40, 7'h79, 7'h24, 7'h30}, 8, 0, 3);
        idle(2);
        wait_frame("t1_timeout");
        idle(10);

        // two anodes low for 20 cycles: nothing captured, no frame
        f0 = frames;
        @(posedge clk); #1;
        an = 4'b1100; sseg = 7'h00;
        repeat (20) @(posedge clk);
        idle(10);
        chk("t3_illegal_noframe", frames, f0);
        sb.push_back('{d0: 4'h0, d1: 4'h8, d2: 4'hF, d3: 4'h5, blank: 4'b0001, err: 4'h0});
        scan({7'h12, 7'h0E, 7'h00, 7'h7F}, 8, 0, 3);
        idle(2);
        wait_frame("t3_timeout");
        idle(10);

        // invalid pattern on digit 2
        sb.push_back('{d0: 4'h1, d1: 4'h2, d2: 4'h0, d3: 4'h3, blank: 4'h0, err: 4'b0100});
        scan({7'h30, 7'h55, 7'h24, 7'h79}, 8, 0, 3);
        idle(2);
        wait_frame("t4_timeout");
        idle(10);

        // long dwell on digit 0: one frame only
        f0 = frames;
        sb.push_back('{d0: 4'hA, d1: 4'hB, d2: 4'hC, d3: 4'hD, blank: 4'h0, err: 4'h0});
        scan({7'h21, 7'h46, 7'h03, 7'h08}, 40, 0, 0);
        scan({7'h21, 7'h46, 7'h03, 7'h08}, 8, 1, 3);
        idle(2);
        wait_frame("t6_timeout");
        idle(20);
        chk("t6_one_frame", frames, f0 + 1);

        // short dwell never captures; stale rises after the timeout
        f0 = frames;
        for (int r = 0; r < 10; r++) scan({7'h21, 7'h46, 7'h03, 7'h08}, SETTLE - 1, 0, 3);
        @(negedge clk);
        chk("t2_not_stale_yet", {31'b0, stale}, 32'd0);
        for (int r = 0; r < 18; r++) scan({7'h21, 7'h46, 7'h03, 7'h08}, SETTLE - 1, 0, 3);
        @(negedge clk);
        chk("t2_no_frame", frames, f0);
        chk("t2_stale", {31'b0, stale}, 32'd1);
        sb.push_back('{d0: 4'h9, d1: 4'h9, d2: 4'h9, d3: 4'h9, blank: 4'h0, err: 4'h0});
        scan({7'h10, 7'h10, 7'h10, 7'h10}, 8, 0, 3);
        idle(2);
        wait_frame("t2_recover_timeout");
        chk("t2_stale_cleared", {31'b0, stale}, 32'd0);

        // reset after two captures: no partial frame survives
        scan({7'h78, 7'h02, 7'h0E, 7'h06}, 8, 0, 1);
        @(posedge clk); #1 reset = 1'b1;
        an = 4'hF; sseg = 7'h7F;
        repeat (2) @(posedge clk);
        check_reset_vals("t5_rst");
        #1 reset = 1'b0;
        f0 = frames;
        scan({7'h78, 7'h02, 7'h0E, 7'h06}, 8, 2, 3);
        idle(20);
        chk("t5_no_partial_frame", frames, f0);
        chk("t5_hold_blank", {28'b0, blank}, 32'hF);
        sb.push_back('{d0: 4'h4, d1: 4'h5, d2: 4'h6, d3: 4'h7, blank: 4'h0, err: 4'h0});
        scan({7'h78, 7'h02, 7'h12, 7'h19}, 8, 0, 3);
        idle(2);
        wait_frame("t5_timeout");
        idle(5);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", nchk);
        $fatal(1);
    end

endmodule
